dcache_load_port: RTL and testbench
===================================

DCACHE_LOAD_PORT -- requirements
Module: dcache_load_port

Interface
REQ-001 Parameters: DEPTH, default 4, request queue entries; AW, default 32, address width; DW, default 32, data width.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Rest  in  1  reset, asynchronous, active-low.
REQ-004 LdpStop  in  1  pipeline stall; freezes load-buffer-side handshakes.
REQ-005 LdpFlash  in  1  flush; discards queued and in-flight loads.
REQ-006 LbToDcdAble  in  1  load-buffer request valid.
REQ-007 LbToDcdAMat  in  2  memory access type; 2'b00 uncached, 2'b01 cached, others treated as cached.
REQ-008 LbToDcdAPtr  in  3  load-buffer slot index 1..7; 0 = no request.
REQ-009 LbToDcdAPhyAddr  in  AW  physical load address.
REQ-010 DcdToLbSuccess  out  1  request accepted this cycle.
REQ-011 DcdToLbBackAble  out  1  load data return valid, one cycle per load.
REQ-012 DcdToLbBackPtr  out  3  slot index of returned load.
REQ-013 DcdToLbBackDate  out  DW  returned load data.
REQ-014 MemReqAble / MemReqAddr / MemReqUncached  out  1 / AW / 1  memory-side read request.
REQ-015 MemReqReady  in  1  memory accepts request.
REQ-016 MemRespAble / MemRespData  in  1 / DW  memory read data valid / data.

Function
REQ-017 Accept when LbToDcdAble=1, LbToDcdAPtr!=0, queue count<DEPTH, LdpStop=0, LdpFlash=0; DcdToLbSuccess is combinational from these in the same cycle.
REQ-018 On accept, push {Ptr, Mat, PhyAddr} at FIFO tail; count increments next edge; no same-cycle bypass of a pop (full stays full that cycle).
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP, DRAIN; reset state IDLE.
REQ-020 IDLE -> ISSUE when count>0.
REQ-021 ISSUE: MemReqAble=1, MemReqAddr=head addr, MemReqUncached=(head Mat==2'b00); MemReqReady=1 -> WAIT.
REQ-022 WAIT: MemRespAble=1 -> capture MemRespData into data register, -> RESP; capture proceeds even when LdpStop=1.
REQ-023 RESP: if LdpStop=0, DcdToLbBackAble=1 with head Ptr and captured data for exactly one cycle, pop head, -> ISSUE if count>1 else IDLE; if LdpStop=1, hold in RESP with BackAble=0.
REQ-024 Exactly one memory request outstanding; loads return in acceptance order.
REQ-025 Minimum latency accept -> BackAble: 4 cycles with MemReqReady and MemRespAble high on first opportunity.
REQ-026 DcdToLbBackPtr, DcdToLbBackDate, MemReqAddr, MemReqUncached SHALL be zero whenever their valid is 0.
REQ-027 LdpFlash (LdpStop=0): FIFO emptied next edge, DcdToLbSuccess and DcdToLbBackAble forced 0 that cycle; from ISSUE/RESP -> IDLE; from WAIT -> DRAIN.
REQ-028 DRAIN: discard the first MemRespAble, then -> IDLE; new requests accepted in DRAIN but not issued until IDLE.
REQ-029 LdpStop has priority over LdpFlash, as in the load buffer; a stalled flash has no effect.
REQ-030 Flash in ISSUE with MemReqReady=1 same cycle: the memory request is considered sent -> DRAIN.
REQ-031 FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

Reset
REQ-032 Rest=0 asynchronously: FSM IDLE, count 0, head/tail 0, data register 0, all outputs 0; takes effect mid-transaction, and any later memory response before a new issue is ignored.

Structure
REQ-033 FSM state encoding, MAT codes (uncached 2'b00, cached 2'b01) and DEPTH default go in the shared define package alongside InstAddrBus/DataBus.
REQ-034 One sub-module: ldp_req_fifo (parameterised DEPTH-entry FIFO, push/pop/flush, count output); FSM and return path in top.

Verification
REQ-035 Single load: Ptr=3, Mat=01, Addr=0x1C00_0040, Ready immediate, resp 0xDEAD_BEEF next cycle -> Success cycle 0, MemReqUncached=0, BackAble with Ptr=3, Date=0xDEAD_BEEF at cycle 4.
REQ-036 Fill: five back-to-back requests Ptr 1..5, Ready held low -> Success for first four only; fifth waits; returns in order 1,2,3,4,5 after Ready released.
REQ-037 Uncached: Mat=00, Addr=0xBFD0_0000 -> MemReqUncached=1, MemReqAddr=0xBFD0_0000.
REQ-038 Flash in WAIT: two queued, LdpFlash during WAIT, resp 0x1234_5678 arrives -> no BackAble, FSM returns IDLE, count 0; next load Ptr=6 returns its own data.
REQ-039 Stop in RESP: LdpStop high 3 cycles at RESP -> BackAble 0 during stop, asserts once on first unstalled cycle with unchanged Ptr/data.
REQ-040 Reset mid-WAIT: Rest low 1 cycle -> all outputs 0 immediately; stale memory response afterward produces no BackAble.

Source files
------------

// File: rtl/dcache_load_port_pkg.sv
// Shared definitions for the data-cache load port: bus widths, queue depth,
// memory access type codes and the load-port FSM state encoding.
package dcache_load_port_pkg;

  localparam int InstAddrBus = 32;
  localparam int DataBus     = 32;

  localparam int LDP_DEPTH = 4;

  localparam logic [1:0] MAT_UNCACHED = 2'b00;
  localparam logic [1:0] MAT_CACHED   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } ldp_state_e;

  // Only the explicit uncached code bypasses the cache; every other code is cached.
  function automatic logic is_uncached(input logic [1:0] mat);
    return mat == MAT_UNCACHED;
  endfunction

endpackage

// File: rtl/dcache_load_port_if.sv
// Load-buffer and memory-side signals of the data-cache load port.
// master: load buffer / memory environment, slave: the load port itself.
interface dcache_load_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          LdpStop;
  logic          LdpFlash;
  logic          LbToDcdAble;
  logic [1:0]    LbToDcdAMat;
  logic [2:0]    LbToDcdAPtr;
  logic [AW-1:0] LbToDcdAPhyAddr;
  logic          DcdToLbSuccess;
  logic          DcdToLbBackAble;
  logic [2:0]    DcdToLbBackPtr;
  logic [DW-1:0] DcdToLbBackDate;
  logic          MemReqAble;
  logic [AW-1:0] MemReqAddr;
  logic          MemReqUncached;
  logic          MemReqReady;
  logic          MemRespAble;
  logic [DW-1:0] MemRespData;

  modport master (
    output LdpStop, LdpFlash, LbToDcdAble, LbToDcdAMat, LbToDcdAPtr, LbToDcdAPhyAddr,
    output MemReqReady, MemRespAble, MemRespData,
    input  DcdToLbSuccess, DcdToLbBackAble, DcdToLbBackPtr, DcdToLbBackDate,
    input  MemReqAble, MemReqAddr, MemReqUncached
  );

  modport slave (
    input  LdpStop, LdpFlash, LbToDcdAble, LbToDcdAMat, LbToDcdAPtr, LbToDcdAPhyAddr,
    input  MemReqReady, MemRespAble, MemRespData,
    output DcdToLbSuccess, DcdToLbBackAble, DcdToLbBackPtr, DcdToLbBackDate,
    output MemReqAble, MemReqAddr, MemReqUncached
  );

endinterface

// File: rtl/dcache_load_port_ldp_req_fifo.sv
// Request queue for the load port: DEPTH-entry circular FIFO with push, pop,
// synchronous flush and an occupancy count. Head entry is always visible.
module ldp_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   Clk,
  input  logic                   Rest,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push_ok;
  logic          pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths still work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_ok = push & (count < CW'(DEPTH));
  assign pop_ok  = pop & (count != '0);
  assign rd_data = mem[head];

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= nxt(tail);
      if (pop_ok)  head <= nxt(head);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (push_ok && !flush) mem[tail] <= wr_data;
  end

endmodule

// File: rtl/dcache_load_port.sv
// Data-cache load port: queues load-buffer requests, issues them one at a
// time to memory, and returns each load's data to the load buffer in order.
module dcache_load_port
  import dcache_load_port_pkg::*;
#(
  parameter int DEPTH = LDP_DEPTH,
  parameter int AW    = InstAddrBus,
  parameter int DW    = DataBus
) (
  input logic               Clk,
  input logic               Rest,
  dcache_load_port_if.slave lp
);

  localparam int EW = 3 + 2 + AW;
  localparam int CW = $clog2(DEPTH) + 1;

  ldp_state_e    state;
  logic [DW-1:0] data_q;
  logic [CW-1:0] count;
  logic [EW-1:0] head_entry;
  logic [2:0]    head_ptr;
  logic [1:0]    head_mat;
  logic [AW-1:0] head_addr;
  logic          flush;
  logic          accept;
  logic          back_able;
  logic          req_able;

  // A stalled flash is ignored, matching the load buffer's own priority.
  assign flush  = lp.LdpFlash & ~lp.LdpStop;
  assign accept = Rest & lp.LbToDcdAble & (lp.LbToDcdAPtr != 3'd0) &
                  (count < CW'(DEPTH)) & ~lp.LdpStop & ~lp.LdpFlash;

  assign back_able = (state == ST_RESP) & ~lp.LdpStop & ~lp.LdpFlash;
  assign req_able  = (state == ST_ISSUE);

  assign head_ptr  = head_entry[EW-1 -: 3];
  assign head_mat  = head_entry[AW+1:AW];
  assign head_addr = head_entry[AW-1:0];

  ldp_req_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .Clk     (Clk),
    .Rest    (Rest),
    .push    (accept),
    .pop     (back_able),
    .flush   (flush),
    .wr_data ({lp.LbToDcdAPtr, lp.LbToDcdAMat, lp.LbToDcdAPhyAddr}),
    .rd_data (head_entry),
    .count   (count)
  );

  // Payload outputs are held at zero whenever their valid is low.
  always_comb begin
    lp.DcdToLbSuccess  = accept;
    lp.DcdToLbBackAble = back_able;
    lp.DcdToLbBackPtr  = back_able ? head_ptr : 3'd0;
    lp.DcdToLbBackDate = back_able ? data_q : '0;
    lp.MemReqAble      = req_able;
    lp.MemReqAddr      = req_able ? head_addr : '0;
    lp.MemReqUncached  = req_able & is_uncached(head_mat);
  end

  // Load sequencing: one outstanding memory read, response captured into data_q.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state  <= ST_IDLE;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!flush && count != '0) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // A request handed over in the flash cycle is already in flight.
          if (lp.MemReqReady) state <= flush ? ST_DRAIN : ST_WAIT;
          else if (flush)     state <= ST_IDLE;
        end
        ST_WAIT: begin
          // A response landing in the flash cycle is the one being discarded.
          if (lp.MemRespAble) begin
            if (flush) begin
              state <= ST_IDLE;
            end else begin
              data_q <= lp.MemRespData;
              state  <= ST_RESP;
            end
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_RESP: begin
          if (flush)             state <= ST_IDLE;
          else if (!lp.LdpStop)  state <= (count > CW'(1)) ? ST_ISSUE : ST_IDLE;
        end
        ST_DRAIN: begin
          if (lp.MemRespAble) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_load_port.sv
// Directed bench for dcache_load_port with hand-computed expected values.
module tb_dcache_load_port;
  import dcache_load_port_pkg::*;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic Clk;
  logic Rest;
  int   vectors;
  int   miscompares;

  dcache_load_port_if #(.AW(32), .DW(32)) lp ();

  dcache_load_port #(
    .DEPTH (4),
    .AW    (32),
    .DW    (32)
  ) dut (
    .Clk  (Clk),
    .Rest (Rest),
    .lp   (lp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    lp.LdpStop         = 1'b0;
    lp.LdpFlash        = 1'b0;
    lp.LbToDcdAble     = 1'b0;
    lp.LbToDcdAMat     = 2'b00;
    lp.LbToDcdAPtr     = 3'd0;
    lp.LbToDcdAPhyAddr = '0;
    lp.MemReqReady     = 1'b1;
    lp.MemRespAble     = 1'b0;
    lp.MemRespData     = '0;
  endtask

  task automatic offer(input logic [2:0] ptr, input logic [1:0] mat, input logic [31:0] addr);
    lp.LbToDcdAble     = 1'b1;
    lp.LbToDcdAPtr     = ptr;
    lp.LbToDcdAMat     = mat;
    lp.LbToDcdAPhyAddr = addr;
  endtask

  task automatic unoffer();
    lp.LbToDcdAble     = 1'b0;
    lp.LbToDcdAPtr     = 3'd0;
    lp.LbToDcdAMat     = 2'b00;
    lp.LbToDcdAPhyAddr = '0;
  endtask

  // Minimum-latency load from an idle, empty port: accept cycle 0, data cycle 4.
  task automatic single_load(input string tag, input logic [2:0] ptr, input logic [1:0] mat,
                             input logic [31:0] addr, input logic [31:0] data);
    offer(ptr, mat, addr);
    #4 chk({tag, "_success"}, lp.DcdToLbSuccess, 1);
    tick(); unoffer();
    #4 chk({tag, "_c1_req"}, lp.MemReqAble, 0);
    tick();
    #4 chk({tag, "_c2_req"}, lp.MemReqAble, 1);
    chk({tag, "_c2_addr"}, lp.MemReqAddr, addr);
    chk({tag, "_c2_unc"}, lp.MemReqUncached, (mat == 2'b00));
    tick(); lp.MemRespAble = 1'b1; lp.MemRespData = data;
    #4 chk({tag, "_c3_req"}, lp.MemReqAble, 0);
    chk({tag, "_c3_addr"}, lp.MemReqAddr, 0);
    chk({tag, "_c3_back"}, lp.DcdToLbBackAble, 0);
    tick(); lp.MemRespAble = 1'b0; lp.MemRespData = '0;
    #4 chk({tag, "_c4_back"}, lp.DcdToLbBackAble, 1);
    chk({tag, "_c4_ptr"}, lp.DcdToLbBackPtr, ptr);
    chk({tag, "_c4_data"}, lp.DcdToLbBackDate, data);
    tick();
    #4 chk({tag, "_c5_back"}, lp.DcdToLbBackAble, 0);
    chk({tag, "_c5_ptr"}, lp.DcdToLbBackPtr, 0);
    chk({tag, "_c5_data"}, lp.DcdToLbBackDate, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        resp_next;
    logic [31:0] resp_dat;
    logic        drop_able;
    int          got;

    vectors = 0;
    miscompares = 0;
    Rest = 1'b0;
    idle_in();
    offer(3'd3, 2'b01, 32'h1000_0000);

    // Reset state: everything quiet, even with a request offered.
    #2 chk("rst_success", lp.DcdToLbSuccess, 0);
    chk("rst_back", lp.DcdToLbBackAble, 0);
    chk("rst_backptr", lp.DcdToLbBackPtr, 0);
    chk("rst_backdata", lp.DcdToLbBackDate, 0);
    chk("rst_req", lp.MemReqAble, 0);
    chk("rst_addr", lp.MemReqAddr, 0);
    chk("rst_unc", lp.MemReqUncached, 0);
    tick(); tick();
    Rest = 1'b1;
    unoffer();
    tick();

    // Single cached load.
    single_load("single", 3'd3, 2'b01, 32'h1C00_0040, 32'hDEAD_BEEF);

    // Uncached load.
    single_load("uncached", 3'd2, 2'b00, 32'hBFD0_0000, 32'h0BAD_F00D);

    // Slot index 0 is never accepted.
    offer(3'd0, 2'b01, 32'h0000_0800);
    #4 chk("ptr0_success", lp.DcdToLbSuccess, 0);
    tick(); unoffer();
    tick();
    #4 chk("ptr0_req", lp.MemReqAble, 0);
    tick();

    // Fill: four accepted with Ready low, fifth refused until a slot frees.
    lp.MemReqReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(3'(i + 1), 2'b01, 32'((i + 1) << 8));
      #4 chk($sformatf("fill_success%0d", i + 1), lp.DcdToLbSuccess, (i < 4));
      tick();
    end
    #4 chk("fill_full_success", lp.DcdToLbSuccess, 0);
    chk("fill_stuck_req", lp.MemReqAble, 1);
    chk("fill_stuck_addr", lp.MemReqAddr, 32'h100);
    tick();
    lp.MemReqReady = 1'b1;
    resp_next = 1'b0;
    resp_dat  = '0;
    drop_able = 1'b0;
    got = 0;
    for (int c = 0; c < 80 && got < 5; c++) begin
      lp.MemRespAble = resp_next;
      lp.MemRespData = resp_next ? resp_dat : '0;
      if (drop_able) unoffer();
      #4;
      if (lp.DcdToLbSuccess) drop_able = 1'b1;
      resp_next = lp.MemReqAble;
      resp_dat  = lp.MemReqAddr ^ K;
      if (lp.DcdToLbBackAble) begin
        chk($sformatf("fill_ret%0d_ptr", got), lp.DcdToLbBackPtr, got + 1);
        chk($sformatf("fill_ret%0d_data", got), lp.DcdToLbBackDate, (32'((got + 1) << 8)) ^ K);
        got++;
      end
      tick();
    end
    chk("fill_returns", got, 5);
    idle_in();
    tick();

    // Flash while waiting for memory: response discarded, queue emptied.
    offer(3'd1, 2'b01, 32'h0000_0100);
    #4 chk("fwait_s1", lp.DcdToLbSuccess, 1);
    tick(); offer(3'd2, 2'b01, 32'h0000_0200);
    #4 chk("fwait_s2", lp.DcdToLbSuccess, 1);
    tick(); unoffer();
    #4 chk("fwait_issue_addr", lp.MemReqAddr, 32'h100);
    tick(); lp.LdpFlash = 1'b1; offer(3'd3, 2'b01, 32'h0000_0300);
    #4 chk("fwait_flash_success", lp.DcdToLbSuccess, 0);
    tick(); lp.LdpFlash = 1'b0; unoffer();
    lp.MemRespAble = 1'b1; lp.MemRespData = 32'h1234_5678;
    #4 chk("fwait_drain_back", lp.DcdToLbBackAble, 0);
    tick(); lp.MemRespAble = 1'b0; lp.MemRespData = '0;
    #4 chk("fwait_idle_back", lp.DcdToLbBackAble, 0);
    chk("fwait_idle_req", lp.MemReqAble, 0);
    tick();
    #4 chk("fwait_empty_req", lp.MemReqAble, 0);
    tick();
    single_load("after_fwait", 3'd6, 2'b01, 32'h1C00_0600, 32'hCAFE_0006);

    // Flash in ISSUE with Ready: request counts as sent, drain its response.
    offer(3'd2, 2'b01, 32'h0000_0200);
    #4 chk("fiss_success", lp.DcdToLbSuccess, 1);
    tick(); unoffer();
    tick(); lp.LdpFlash = 1'b1;
    #4 chk("fiss_req", lp.MemReqAble, 1);
    tick(); lp.LdpFlash = 1'b0;
    lp.MemRespAble = 1'b1; lp.MemRespData = 32'h0000_2222;
    offer(3'd7, 2'b00, 32'h0000_0700);
    #4 chk("fiss_drain_back", lp.DcdToLbBackAble, 0);
    chk("fiss_drain_req", lp.MemReqAble, 0);
    chk("fiss_drain_accept", lp.DcdToLbSuccess, 1);
    tick(); lp.MemRespAble = 1'b0; lp.MemRespData = '0; unoffer();
    #4 chk("fiss_idle_req", lp.MemReqAble, 0);
    tick();
    #4 chk("fiss_new_req", lp.MemReqAble, 1);
    chk("fiss_new_addr", lp.MemReqAddr, 32'h700);
    chk("fiss_new_unc", lp.MemReqUncached, 1);
    tick(); lp.MemRespAble = 1'b1; lp.MemRespData = 32'h7777_0007;
    tick(); lp.MemRespAble = 1'b0; lp.MemRespData = '0;
    #4 chk("fiss_new_back", lp.DcdToLbBackAble, 1);
    chk("fiss_new_ptr", lp.DcdToLbBackPtr, 7);
    chk("fiss_new_data", lp.DcdToLbBackDate, 32'h7777_0007);
    tick(); tick();

    // Stop held three cycles in RESP; a stalled flash and request are ignored.
    offer(3'd4, 2'b01, 32'h0000_0400);
    #4 chk("stop_success", lp.DcdToLbSuccess, 1);
    tick(); unoffer();
    tick();
    tick(); lp.MemRespAble = 1'b1; lp.MemRespData = 32'h4444_0004;
    tick(); lp.MemRespAble = 1'b0; lp.MemRespData = '0;
    lp.LdpStop = 1'b1; offer(3'd7, 2'b01, 32'h0000_0700);
    for (int s = 0; s < 3; s++) begin
      lp.LdpFlash = (s == 1);
      #4 chk($sformatf("stop%0d_back", s), lp.DcdToLbBackAble, 0);
      chk($sformatf("stop%0d_ptr", s), lp.DcdToLbBackPtr, 0);
      chk($sformatf("stop%0d_data", s), lp.DcdToLbBackDate, 0);
      chk($sformatf("stop%0d_success", s), lp.DcdToLbSuccess, 0);
      tick();
    end
    lp.LdpStop = 1'b0; lp.LdpFlash = 1'b0; unoffer();
    #4 chk("stop_rel_back", lp.DcdToLbBackAble, 1);
    chk("stop_rel_ptr", lp.DcdToLbBackPtr, 4);
    chk("stop_rel_data", lp.DcdToLbBackDate, 32'h4444_0004);
    tick();
    #4 chk("stop_after_back", lp.DcdToLbBackAble, 0);
    tick();
    #4 chk("stop_after_req", lp.MemReqAble, 0);
    tick();

    // Reset mid-WAIT, then a stale response.
    offer(3'd5, 2'b01, 32'h0000_0500);
    #4 chk("rwait_success", lp.DcdToLbSuccess, 1);
    tick(); unoffer();
    tick();
    tick();
    Rest = 1'b0; offer(3'd2, 2'b01, 32'h0000_0900);
    #1 chk("rwait_rst_success", lp.DcdToLbSuccess, 0);
    chk("rwait_rst_req", lp.MemReqAble, 0);
    chk("rwait_rst_back", lp.DcdToLbBackAble, 0);
    chk("rwait_rst_addr", lp.MemReqAddr, 0);
    tick(); Rest = 1'b1; unoffer();
    lp.MemRespAble = 1'b1; lp.MemRespData = 32'hBAD0_0BAD;
    #4 chk("rwait_stale_back", lp.DcdToLbBackAble, 0);
    tick(); lp.MemRespAble = 1'b0; lp.MemRespData = '0;
    #4 chk("rwait_after_back", lp.DcdToLbBackAble, 0);
    chk("rwait_after_req", lp.MemReqAble, 0);
    tick();
    single_load("after_rst", 3'd1, 2'b10, 32'h1C00_0100, 32'h0101_0101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
